// File: rtl/i2s_tx_mono_if.sv
// Sample stream into the I2S transmitter and the serial DAC pins it drives.
// master = upstream sample source / pin observer, slave = transmitter.
interface i2s_tx_mono_if #(
  parameter int G_DWIDTH = 24
);
  logic signed [G_DWIDTH-1:0] din;
  logic                       din_valid;
  logic                       din_ready;
  logic                       i2s_bclk;
  logic                       i2s_lrclk;
  logic                       i2s_sdata;
  logic                       underflow;

  modport master (
    output din, din_valid,
    input  din_ready, i2s_bclk, i2s_lrclk, i2s_sdata, underflow
  );

  modport slave (
    input  din, din_valid,
    output din_ready, i2s_bclk, i2s_lrclk, i2s_sdata, underflow
  );
endinterface

// File: rtl/i2s_tx_mono.sv
// Mono I2S transmitter: one accepted sample is sent MSB-first in both slots of a
// frame; bclk/lrclk come from an integer divider of clk.
module i2s_tx_mono #(
  parameter int G_DWIDTH     = 24,
  parameter int G_SLOT_WIDTH = 32,
  parameter int G_BCLK_DIV   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  i2s_tx_mono_if.slave bus
);

  localparam int DIV_W = (G_BCLK_DIV > 1) ? $clog2(G_BCLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * G_SLOT_WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(G_BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * G_SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(G_SLOT_WIDTH);

  if (G_SLOT_WIDTH < G_DWIDTH + 1) begin : g_bad_slot
    $error("G_SLOT_WIDTH must be at least G_DWIDTH+1");
  end
  if (G_BCLK_DIV < 1) begin : g_bad_div
    $error("G_BCLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0]           div_cnt;
  logic [CNT_W-1:0]           bit_cnt;
  logic                       bclk;
  logic                       lrclk;
  logic                       sdata;
  logic                       underflow;
  logic                       hold_full;
  logic signed [G_DWIDTH-1:0] hold_reg;
  logic signed [G_DWIDTH-1:0] frame_reg;

  logic                       wrap;
  logic                       fall;
  logic                       frame_start;
  logic                       xfer;
  logic [CNT_W-1:0]           bit_nxt;
  logic [CNT_W-1:0]           slot_pos;
  logic                       lr_nxt;
  logic                       sdata_nxt;

  // Slot position pos carries sample bit G_DWIDTH-pos for pos in 1..G_DWIDTH;
  // position 0 is the one-bclk I2S delay bit and the slot tail is zero-filled.
  function automatic logic slot_bit(input logic signed [G_DWIDTH-1:0] frame,
                                    input int pos);
    logic b;
    b = 1'b0;
    for (int i = 0; i < G_DWIDTH; i++) begin
      if (pos == G_DWIDTH - i) b = frame[i];
    end
    return b;
  endfunction

  always_comb begin
    wrap        = (div_cnt == DIV_LAST);
    fall        = wrap & bclk;
    bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    lr_nxt      = (bit_nxt >= SLOT_LEN);
    slot_pos    = lr_nxt ? (bit_nxt - SLOT_LEN) : bit_nxt;
    sdata_nxt   = slot_bit(frame_reg, int'(slot_pos));
    frame_start = fall & (bit_nxt == '0);
    xfer        = bus.din_valid & bus.din_ready;
  end

  // Stage: bit timing, frame sequencing and holding-register handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= BIT_LAST;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      underflow <= 1'b0;
      hold_full <= 1'b0;
      frame_reg <= '0;
    end else if (!enable) begin
      div_cnt   <= '0;
      bit_cnt   <= BIT_LAST;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      underflow <= 1'b0;
      hold_full <= 1'b0;
      frame_reg <= '0;
    end else begin
      if (wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= lr_nxt;
        sdata   <= sdata_nxt;
      end

      underflow <= frame_start & ~hold_full;

      if (frame_start) begin
        frame_reg <= hold_full ? hold_reg : '0;
      end

      // A transfer implies the register was empty, so it never races a drain.
      if (frame_start && hold_full) begin
        hold_full <= 1'b0;
      end else if (xfer) begin
        hold_full <= 1'b1;
      end
    end
  end

  // Stage: sample capture (data only, qualified by the handshake)
  always_ff @(posedge clk) begin
    if (xfer) hold_reg <= bus.din;
  end

  assign bus.din_ready = ~hold_full & enable;
  assign bus.i2s_bclk  = bclk;
  assign bus.i2s_lrclk = lrclk;
  assign bus.i2s_sdata = sdata;
  assign bus.underflow = underflow;

endmodule

// File: tb/tb_i2s_tx_mono.sv
// Bench for i2s_tx_mono: frames decoded from the serial pins on bclk rising
// edges are scored against per-scenario expected frames.
module tb_i2s_tx_mono;

  localparam int DW   = 24;
  localparam int SLOT = 32;
  localparam int DIV  = 2;

  typedef struct packed {
    logic [SLOT-1:0] l;
    logic [SLOT-1:0] r;
    logic            uf;
  } frame_t;

  logic clk;
  logic reset;
  logic enable;

  int n_cmp;
  int n_fail;
  int cur;

  frame_t obs_q[$];
  frame_t exp_q[$];

  i2s_tx_mono_if #(.G_DWIDTH(DW)) bus ();

  i2s_tx_mono #(
    .G_DWIDTH    (DW),
    .G_SLOT_WIDTH(SLOT),
    .G_BCLK_DIV  (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: rebuild frames from the pins as a DAC would see them.
  int              fpos;
  bit              fvalid;
  bit              uf_pend;
  bit              cur_uf;
  logic            prev_bclk;
  logic [SLOT-1:0] cur_l;
  logic [SLOT-1:0] cur_r;

  always @(negedge clk) begin
    if (reset || !enable) begin
      fpos      = 2 * SLOT - 2;
      fvalid    = 0;
      uf_pend   = 0;
      prev_bclk = 1'b0;
    end else begin
      if (bus.underflow === 1'b1) uf_pend = 1;
      if (bus.i2s_bclk === 1'b1 && prev_bclk === 1'b0) begin
        fpos = (fpos + 1) % (2 * SLOT);
        if (fpos == 0) begin
          fvalid  = 1;
          cur_uf  = uf_pend;
          uf_pend = 0;
          cur_l   = '0;
          cur_r   = '0;
        end
        if (fvalid) begin
          n_cmp++;
          if (bus.i2s_lrclk !== (fpos >= SLOT)) begin
            n_fail++;
            $display("FAIL lrclk_slot pos=%0d got %b want %b", fpos, bus.i2s_lrclk, (fpos >= SLOT));
          end
          if (fpos < SLOT) cur_l[SLOT-1-fpos] = bus.i2s_sdata;
          else             cur_r[2*SLOT-1-fpos] = bus.i2s_sdata;
          if (fpos == 2 * SLOT - 1) obs_q.push_back('{l: cur_l, r: cur_r, uf: cur_uf});
        end
      end
      prev_bclk = bus.i2s_bclk;
    end
  end

  function automatic frame_t mk_frame(input logic [DW-1:0] s, input logic uf);
    logic [SLOT-1:0] w;
    w = {1'b0, s, {(SLOT-DW-1){1'b0}}};
    return '{l: w, r: w, uf: uf};
  endfunction

  task automatic cyc_to(input int c);
    while (cur < c) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    enable        = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    cur = -1;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    bus.din_valid = 1'b0;
    bus.din = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata, bus.underflow} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outs got %b want 0000", {bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata, bus.underflow});
    end
    reset = 1'b0;
    cur = -1;
    obs_q.delete();
    exp_q.delete();
    for (int c = 0; c <= 4; c++) begin
      logic [1:0] want_b;
      cyc_to(c);
      want_b[1] = (c == 1 || c == 2);
      want_b[0] = (c == 3);
      n_cmp++;
      if ({bus.i2s_bclk, bus.underflow} !== want_b) begin
        n_fail++;
        $display("FAIL start_timing cyc=%0d got bclk,uf=%b want %b", c, {bus.i2s_bclk, bus.underflow}, want_b);
      end
    end
    n_cmp++;
    if (bus.i2s_lrclk !== 1'b0) begin
      n_fail++;
      $display("FAIL start_lrclk got %b want 0", bus.i2s_lrclk);
    end
    cyc_to(170);
    n_cmp++;
    if (bus.i2s_lrclk !== 1'b1) begin
      n_fail++;
      $display("FAIL right_slot_lrclk got %b want 1", bus.i2s_lrclk);
    end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata, bus.underflow} !== 4'b0) begin
      n_fail++;
      $display("FAIL async_reset got %b want 0000", {bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata, bus.underflow});
    end
  endtask

  task automatic test_single();
    bit ok;
    frame_t got, e;
    do_reset();
    bus.din = 24'hA5C3F1;
    bus.din_valid = 1'b1;
    exp_q.push_back(mk_frame(24'hA5C3F1, 1'b0));
    cyc_to(0);
    bus.din_valid = 1'b0;
    n_cmp++;
    if (bus.din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready_full got %b want 0", bus.din_ready);
    end
    cyc_to(3);
    n_cmp++;
    if (bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_uf got %b want 0", bus.underflow);
    end
    cyc_to(6);
    n_cmp++;
    if (bus.i2s_sdata !== 1'b0) begin
      n_fail++;
      $display("FAIL single_delay_bit got %b want 0", bus.i2s_sdata);
    end
    cyc_to(7);
    n_cmp++;
    if (bus.i2s_sdata !== 1'b1) begin
      n_fail++;
      $display("FAIL single_msb_latency got %b want 1", bus.i2s_sdata);
    end
    cyc_to(99);
    n_cmp++;
    if (bus.i2s_sdata !== 1'b1) begin
      n_fail++;
      $display("FAIL single_lsb got %b want 1", bus.i2s_sdata);
    end
    cyc_to(103);
    n_cmp++;
    if (bus.i2s_sdata !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pad got %b want 0", bus.i2s_sdata);
    end
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_timeout got %0d frames want %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        got = obs_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL single_frame got l=%h r=%h uf=%b want l=%h r=%h uf=%b", got.l, got.r, got.uf, e.l, e.r, e.uf);
        end
      end
    end
  endtask

  task automatic test_underflow();
    bit ok;
    frame_t got, e;
    do_reset();
    for (int c = 0; c <= 520; c++) begin
      logic want_uf;
      cyc_to(c);
      want_uf = (c == 3 || c == 259 || c == 515);
      n_cmp++;
      if ({bus.underflow, bus.i2s_sdata} !== {want_uf, 1'b0}) begin
        n_fail++;
        $display("FAIL uf_idle cyc=%0d got uf,sdata=%b%b want %b0", c, bus.underflow, bus.i2s_sdata, want_uf);
      end
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(mk_frame('0, 1'b1));
    bus.din = 24'h7FFFFF;
    bus.din_valid = 1'b1;
    exp_q.push_back(mk_frame(24'h7FFFFF, 1'b0));
    cyc_to(521);
    bus.din_valid = 1'b0;
    cyc_to(771);
    n_cmp++;
    if (bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_recover got %b want 0", bus.underflow);
    end
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL uf_timeout got %0d frames want %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        got = obs_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL uf_frame got l=%h r=%h uf=%b want l=%h r=%h uf=%b", got.l, got.r, got.uf, e.l, e.r, e.uf);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    frame_t got, e;
    int k;
    int rises;
    logic acc;
    logic rdy_prev;
    do_reset();
    k = 0;
    rises = 0;
    bus.din = 24'hC00000;
    bus.din_valid = 1'b1;
    rdy_prev = bus.din_ready;
    for (int c = 0; c <= 1030; c++) begin
      acc = bus.din_valid & bus.din_ready;
      cyc_to(c);
      if (acc) begin
        exp_q.push_back(mk_frame(bus.din, 1'b0));
        k++;
        bus.din = 24'hC00000 + 24'(k);
        if (k == 4) bus.din_valid = 1'b0;
      end
      if (bus.din_ready === 1'b1 && rdy_prev === 1'b0) begin
        rises++;
        n_cmp++;
        if ((c - 3) % 256 != 0) begin
          n_fail++;
          $display("FAIL bp_ready_rise got cyc=%0d want 3+256n", c);
        end
      end
      rdy_prev = bus.din_ready;
    end
    n_cmp++;
    if (rises != 4 || k != 4) begin
      n_fail++;
      $display("FAIL bp_counts got rises=%0d accepts=%0d want 4/4", rises, k);
    end
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_timeout got %0d frames want %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        got = obs_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL bp_frame got l=%h r=%h uf=%b want l=%h r=%h uf=%b", got.l, got.r, got.uf, e.l, e.r, e.uf);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    frame_t got, e;
    do_reset();
    cyc_to(2);
    bus.din = 24'h3C96E1;
    bus.din_valid = 1'b1;
    exp_q.push_back(mk_frame('0, 1'b1));
    exp_q.push_back(mk_frame(24'h3C96E1, 1'b0));
    cyc_to(3);
    bus.din_valid = 1'b0;
    n_cmp++;
    if ({bus.underflow, bus.din_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL simul_uf_ready got %b want 10", {bus.underflow, bus.din_ready});
    end
    cyc_to(4);
    n_cmp++;
    if (bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_uf_pulse got %b want 0", bus.underflow);
    end
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL simul_timeout got %0d frames want %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        got = obs_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL simul_frame got l=%h r=%h uf=%b want l=%h r=%h uf=%b", got.l, got.r, got.uf, e.l, e.r, e.uf);
        end
      end
    end
  endtask

  task automatic test_enable();
    bit ok;
    frame_t got, e;
    do_reset();
    bus.din = 24'h123456;
    bus.din_valid = 1'b1;
    cyc_to(0);
    bus.din_valid = 1'b0;
    cyc_to(10);
    bus.din = 24'h654321;
    bus.din_valid = 1'b1;
    cyc_to(11);
    bus.din_valid = 1'b0;
    n_cmp++;
    if (bus.din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL en_hold_full got %b want 0", bus.din_ready);
    end
    cyc_to(190);
    n_cmp++;
    if (bus.i2s_lrclk !== 1'b1) begin
      n_fail++;
      $display("FAIL en_pre_lrclk got %b want 1", bus.i2s_lrclk);
    end
    enable = 1'b0;
    bus.din = 24'hABCDEF;
    bus.din_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL en_ready_drop got %b want 0", bus.din_ready);
    end
    for (int c = 191; c <= 200; c++) begin
      cyc_to(c);
      n_cmp++;
      if ({bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata, bus.underflow, bus.din_ready} !== 5'b0) begin
        n_fail++;
        $display("FAIL en_off cyc=%0d got %b want 00000", c,
                 {bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata, bus.underflow, bus.din_ready});
      end
    end
    enable = 1'b1;
    bus.din_valid = 1'b0;
    exp_q.push_back(mk_frame('0, 1'b1));
    cyc_to(202);
    n_cmp++;
    if (bus.i2s_bclk !== 1'b1) begin
      n_fail++;
      $display("FAIL en_bclk_rise got %b want 1", bus.i2s_bclk);
    end
    cyc_to(204);
    n_cmp++;
    if ({bus.i2s_bclk, bus.i2s_lrclk, bus.underflow, bus.din_ready} !== 4'b0011) begin
      n_fail++;
      $display("FAIL en_restart got bclk,lr,uf,rdy=%b want 0011",
               {bus.i2s_bclk, bus.i2s_lrclk, bus.underflow, bus.din_ready});
    end
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL en_timeout got %0d frames want %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        got = obs_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL en_frame got l=%h r=%h uf=%b want l=%h r=%h uf=%b", got.l, got.r, got.uf, e.l, e.r, e.uf);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    cur = -1;
    test_reset();
    test_single();
    test_underflow();
    test_back_to_back();
    test_simultaneous();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
